// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU operation codes and datapath select values.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [2:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface mips_mc_control_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic       pcen;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output aluop, alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
               irwrite, pcwrite, branch, regwrite, memwrite, pcen, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  aluop, alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
               irwrite, pcwrite, branch, regwrite, memwrite, pcen, illegal, state
    );

endinterface

// File: rtl/mips_mc_outdec.sv
// State -> control-word decoder. MIPS_MC_ADDI_EN enables the ADDIEX/ADDIWB words.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.alusrcb = SRCB_FOUR;
                ctrl_o.aluop   = ALUOP_ADD;
                ctrl_o.irwrite = mem_ready_i;
                ctrl_o.pcwrite = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alusrcb = SRCB_IMMSH;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMRD: ctrl_o.iord = 1'b1;
            S_MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_REGB;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
            end
`ifdef MIPS_MC_ADDI_EN
            S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: ctrl_o.regwrite = 1'b1;
`endif
            S_JEX: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM. Define MIPS_MC_ADDI_EN to decode addi.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mips_mc_control_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   illegal_d;

    mips_mc_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
`ifdef MIPS_MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // lw and sw differ only in opcode bit 3
            S_MEMADR:  state_d = bus.opcode[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
`ifdef MIPS_MC_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`endif
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Enables are masked by reset so FETCH's mem_ready-driven writes cannot leak through
    assign bus.aluop    = ctrl.aluop;
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.pcsrc    = ctrl.pcsrc;
    assign bus.iord     = ctrl.iord;
    assign bus.regdst   = ctrl.regdst;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.irwrite  = ctrl.irwrite  & ~reset;
    assign bus.pcwrite  = ctrl.pcwrite  & ~reset;
    assign bus.branch   = ctrl.branch   & ~reset;
    assign bus.regwrite = ctrl.regwrite & ~reset;
    assign bus.memwrite = ctrl.memwrite & ~reset;
    assign bus.pcen     = (ctrl.pcwrite | (ctrl.branch & bus.zero)) & ~reset;
    assign bus.illegal  = illegal_d & ~reset;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized self-checking bench for mips_mc_control against a per-instruction path model.
module tb_mips_mc_control;

`ifdef MIPS_MC_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] st;
        logic       mr;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    mips_mc_control_if bus ();

    mips_mc_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [17:0] obs_word = {bus.aluop, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.iord,
                            bus.regdst, bus.memtoreg, bus.irwrite, bus.pcwrite,
                            bus.branch, bus.regwrite, bus.memwrite, bus.pcen, bus.illegal};

    // alusrcb = 01, everything else 0
    localparam logic [17:0] RESET_WORD = 18'b000_0_01_00_0_0_0_0_0_0_0_0_0_0;

    function automatic bit is_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000010) || (ADDI_EN && op == 6'b001000);
    endfunction

    // Expected control outputs for a state, written from the per-state output lists.
    function automatic logic [17:0] exp_word(input logic [3:0] st, input logic mr,
                                             input logic z, input logic [5:0] op);
        logic [2:0] aluop = 3'b000;
        logic       a = 0, iord = 0, rd = 0, m2r = 0, irw = 0, pcw = 0;
        logic       br = 0, rw = 0, mw = 0, ill = 0;
        logic [1:0] b = 2'b00, pcs = 2'b00;
        case (st)
            4'd0:  begin b = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin b = 2'b11; ill = !is_legal(op); end
            4'd2:  begin a = 1; b = 2'b10; end
            4'd3:  iord = 1;
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iord = 1; mw = 1; end
            4'd6:  begin a = 1; aluop = 3'b010; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin a = 1; aluop = 3'b001; pcs = 2'b01; br = 1; end
            4'd9:  if (ADDI_EN) begin a = 1; b = 2'b10; end
            4'd10: if (ADDI_EN) rw = 1;
            4'd11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {aluop, a, b, pcs, iord, rd, m2r, irw, pcw, br, rw, mw, pcw | (br & z), ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Applies one cycle of inputs, checks state and outputs, and advances to posedge+2.
    task automatic do_step(input step_t s, input logic [5:0] op, input int zsel);
        logic z;
        z = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
        bus.opcode    = op;
        bus.mem_ready = s.mr;
        bus.zero      = z;
        #1;
        check($sformatf("state op=%b", op), {28'd0, bus.state}, {28'd0, s.st});
        check($sformatf("ctrl st=%0d op=%b", s.st, op), {14'd0, obs_word},
              {14'd0, exp_word(s.st, s.mr, z, op)});
        @(posedge clk);
        #2;
    endtask

    // Builds the expected state path of one instruction from its class and wait counts.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mwait, input int zsel);
        step_t q[$];
        for (int i = 0; i < fw; i++) q.push_back('{4'd0, 1'b0});
        q.push_back('{4'd0, 1'b1});
        q.push_back('{4'd1, 1'($urandom_range(0, 1))});
        if (op == 6'b100011 || op == 6'b101011) begin
            logic [3:0] ms;
            ms = (op == 6'b100011) ? 4'd3 : 4'd5;
            q.push_back('{4'd2, 1'($urandom_range(0, 1))});
            for (int i = 0; i < mwait; i++) q.push_back('{ms, 1'b0});
            q.push_back('{ms, 1'b1});
            if (op == 6'b100011) q.push_back('{4'd4, 1'($urandom_range(0, 1))});
        end else if (op == 6'b000000) begin
            q.push_back('{4'd6, 1'($urandom_range(0, 1))});
            q.push_back('{4'd7, 1'($urandom_range(0, 1))});
        end else if (op == 6'b000100) begin
            q.push_back('{4'd8, 1'($urandom_range(0, 1))});
        end else if (op == 6'b000010) begin
            q.push_back('{4'd11, 1'($urandom_range(0, 1))});
        end else if (ADDI_EN && op == 6'b001000) begin
            q.push_back('{4'd9, 1'($urandom_range(0, 1))});
            q.push_back('{4'd10, 1'($urandom_range(0, 1))});
        end
        foreach (q[i]) do_step(q[i], op, zsel);
    endtask

    logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    initial begin
        logic [5:0] op;
        bus.opcode    = 6'b101011;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        check("reset state", {28'd0, bus.state}, 32'd0);
        check("reset outputs", {14'd0, obs_word}, {14'd0, RESET_WORD});
        reset = 1'b0;

        run_instr(6'b100011, 0, 0, 2);
        run_instr(6'b101011, 0, 2, 2);
        run_instr(6'b000100, 0, 0, 1);
        run_instr(6'b000100, 1, 0, 0);
        run_instr(6'b000000, 0, 0, 2);
        run_instr(6'b111111, 0, 0, 2);
        run_instr(6'b001000, 0, 0, 2);
        run_instr(6'b000010, 2, 0, 2);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                op = 6'($urandom_range(0, 63));
                for (int k = 0; k < 64 && is_legal(op); k++) op = op + 6'd1;
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), 2);
        end

        // Reset in the middle of a sw write that is still waiting on memory
        do_step('{4'd0, 1'b1}, 6'b101011, 2);
        do_step('{4'd1, 1'b0}, 6'b101011, 2);
        do_step('{4'd2, 1'b0}, 6'b101011, 2);
        bus.mem_ready = 1'b0;
        #1;
        check("memwr state", {28'd0, bus.state}, 32'd5);
        check("memwr memwrite", {31'd0, bus.memwrite}, 32'd1);
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("async reset state", {28'd0, bus.state}, 32'd0);
        check("async reset outputs", {14'd0, obs_word}, {14'd0, RESET_WORD});
        @(posedge clk);
        #2;
        check("held reset outputs", {14'd0, obs_word}, {14'd0, RESET_WORD});
        reset = 1'b0;
        #1;
        check("post reset alusrcb", {30'd0, bus.alusrcb}, 32'd1);
        @(posedge clk);
        #2;
        check("post reset decode", {28'd0, bus.state}, 32'd1);
        do_step('{4'd1, 1'b1}, 6'b000010, 2);
        do_step('{4'd11, 1'b1}, 6'b000010, 2);
        run_instr(6'b100011, 1, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle main control FSM for the MIPS datapath. It decodes the instruction-register opcode and sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath mux selects and write enables, and produces `aluop` for the ALU controller directly downstream. Memory accesses wait on a ready handshake, so instruction and data memory can have variable latency.

## Interface
Parameters:
- none (encodings live in the shared package)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  6  instr[31:26] from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current read or write this cycle
- `aluop`  out  3  to the ALU controller: 000 = add, 001 = sub, 010 = decode funct
- `alusrca`  out  1  0 = PC, 1 = register A
- `alusrcb`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `regdst`  out  1  destination register: 0 = rt, 1 = rd
- `memtoreg`  out  1  writeback data: 0 = ALUOut, 1 = MDR
- `irwrite`, `pcwrite`, `branch`, `regwrite`, `memwrite`  out  1 each  enables
- `pcen`  out  1  `pcwrite | (branch & zero)`
- `illegal`  out  1  one-cycle pulse on an unsupported opcode
- `state`  out  4  current state, for debug

## Operation
All outputs are Moore outputs decoded from `state`, with three exceptions: the FETCH write enables, `pcen`, and `illegal`. Any output not listed for a state is 0.

State encodings and per-state behaviour:
- FETCH (0)
  - `alusrcb` = 01, `aluop` = 000.
  - `irwrite` = `pcwrite` = `mem_ready`.
  - Stay in FETCH while `mem_ready` = 0; go to DECODE when it is 1.
- DECODE (1)
  - `alusrcb` = 11, `aluop` = 000.
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → RTYPEEX
    - 000100 (beq) → BEQEX
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JEX
    - anything else: `illegal` = 1, next state FETCH.
- MEMADR (2)
  - `alusrca` = 1, `alusrcb` = 10, `aluop` = 000.
  - lw → MEMRD; sw → MEMWR.
- MEMRD (3)
  - `iord` = 1.
  - Hold until `mem_ready`, then → MEMWB.
- MEMWB (4)
  - `memtoreg` = 1, `regwrite` = 1.
  - → FETCH.
- MEMWR (5)
  - `iord` = 1, `memwrite` = 1, held asserted until `mem_ready`.
  - Then → FETCH.
- RTYPEEX (6)
  - `alusrca` = 1, `alusrcb` = 00, `aluop` = 010.
  - → RTYPEWB.
- RTYPEWB (7)
  - `regdst` = 1, `regwrite` = 1.
  - → FETCH.
- BEQEX (8)
  - `alusrca` = 1, `aluop` = 001, `pcsrc` = 01, `branch` = 1.
  - → FETCH.
- ADDIEX (9)
  - `alusrca` = 1, `alusrcb` = 10, `aluop` = 000.
  - → ADDIWB.
- ADDIWB (10)
  - `regwrite` = 1.
  - → FETCH.
- JEX (11)
  - `pcsrc` = 10, `pcwrite` = 1.
  - → FETCH.
- Unused encodings 12–15 → FETCH, with all outputs 0.

Opcode sampling:
- `opcode` is sampled only in DECODE; the instruction register holds it stable from then on.
- MEMADR re-reads `opcode` bit 3 to choose lw or sw.

## Timing
Reset:
- `reset` forces `state` = FETCH asynchronously.
- While `reset` is high, all enables and `illegal` are 0; the remaining outputs take their FETCH values.
- Reset asserted in the middle of an instruction aborts it. No write enable may glitch high during reset.

Latency with `mem_ready` tied to 1:
- lw: 5 cycles
- sw, R-type, addi: 4 cycles
- beq, j: 3 cycles
- Each cycle with `mem_ready` = 0 in FETCH, MEMRD or MEMWR adds one cycle.

Other timing rules:
- `pcen` follows `zero` combinationally in BEQEX.
- `illegal` is high for exactly one cycle, in DECODE.

## Configuration
- `MIPS_MC_ADDI_EN` defined: opcode 001000 is decoded and ADDIEX/ADDIWB exist.
- `MIPS_MC_ADDI_EN` undefined: opcode 001000 is illegal (`illegal` pulse, next state FETCH). Encodings 9 and 10 become unused.

## Structure
Shared package `mips_pkg` holds:
- state encoding constants
- opcode constants
- `aluop` constants (000, 001, 010)
- `alusrcb` and `pcsrc` select constants

The ALU controller imports the same `aluop` constants.

One sub-module, `mips_mc_outdec`: combinational state → control-word decoder. The FSM register and next-state logic stay in the top module.

## Test plan
- Reset:
  - Stimulus: `reset` high mid-MEMWR, with `memwrite` = 1.
  - Response: `state` = 0 immediately, `memwrite` = 0. After release, FETCH with `alusrcb` = 01.
- lw:
  - Stimulus: opcode 100011, `mem_ready` = 1.
  - Response: state sequence 0, 1, 2, 3, 4, 0. `regwrite` and `memtoreg` are 1 only in state 4.
- sw with wait states:
  - Stimulus: opcode 101011, `mem_ready` low for 2 cycles in MEMWR.
  - Response: `memwrite` high for 3 cycles, then FETCH.
- beq:
  - Stimulus: opcode 000100 with `zero` = 1, then repeated with `zero` = 0.
  - Response: `pcen` = 1 in BEQEX for `zero` = 1, 0 for `zero` = 0. `aluop` = 001 in both cases.
- R-type:
  - Stimulus: opcode 000000.
  - Response: `aluop` = 010 in state 6; `regdst` = 1 and `regwrite` = 1 in state 7.
- Illegal / addi:
  - Stimulus: opcode 111111, then 001000 built with and without `MIPS_MC_ADDI_EN`.
  - Response: 111111 gives `illegal` high for one cycle, then `state` = 0. 001000 reaches state 9 with the macro defined, and gives an `illegal` pulse without it.
